pong_rally_judge: RTL and testbench
===================================

Name: pong_rally_judge

Overview:
- Receiving end of the LED light-pattern interface. It samples the 8-bit one-hot ball pattern that the light pattern generator drives.
- Decodes ball position and direction, judges paddle hits from the two player buttons, and feeds a 1-cycle Bounce request back to the generator.
- Keeps both players' scores and declares the winner. Sits between the pattern generator and the score display logic in the Pong top level.

Parameters:
- WIDTH, 8, number of LEDs / pattern bits (position width is clog2(WIDTH)).
- SCORE_W, 4, width of each score counter.
- WIN_SCORE, 9, score at which the game ends.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-low reset.
- Pattern  in  WIDTH  LED pattern from the generator; bit WIDTH-1 is the left end, bit 0 is the right end.
- Step  in  1  1-cycle pulse; the generator has just advanced the pattern.
- BtnL  in  1  left paddle button, debounced level.
- BtnR  in  1  right paddle button, debounced level.
- Bounce  out  1  1-cycle pulse requesting a direction reversal.
- Pos  out  clog2(WIDTH)  last decoded ball index.
- Dir  out  1  1 = moving left (index increasing), 0 = moving right.
- ScoreL  out  SCORE_W  left player score.
- ScoreR  out  SCORE_W  right player score.
- Winner  out  2  00 none, 10 left, 01 right.
- Err  out  1  1-cycle pulse on an illegal pattern or illegal step.

Behaviour:
- Reset (Rst=0 at a clock edge): all outputs are 0, state is IDLE, the previous-position register is cleared, and the button edge registers are cleared. Reset applies mid-rally or in GAMEOVER with the same effect.
- Button handling: BtnL and BtnR are registered; a rising edge is (cur & ~prev). The edge is visible in the cycle after the level change.
- Pattern sampling happens only in cycles where Step=1.
  - Legal pattern: exactly one bit set. Pos is updated to that index, registered, with Pos valid the cycle after Step.
  - Illegal pattern (zero bits or more than one bit set): Err pulses, Pos holds, state does not change.
- Direction: while in RALLY, the new index is compared with the previous index.
  - +1: Dir=1.
  - -1: Dir=0.
  - 0 or a jump of 2 or more: Err pulses and Dir holds.
- States:
  - IDLE: the first legal Step loads Pos. Dir is set from position (index >= WIDTH/2 gives Dir=0, otherwise Dir=1). Next state is RALLY.
  - RALLY:
    - A legal Step landing on index WIDTH-1 with Dir=1 goes to AT_LEFT.
    - A legal Step landing on index 0 with Dir=0 goes to AT_RIGHT.
    - Button edges in RALLY are ignored; there is no penalty for early presses.
  - AT_LEFT:
    - A BtnL rising edge makes Bounce=1 for exactly one cycle, sets Dir to 0, and returns to RALLY.
    - A Step with no hit yet increments ScoreR and goes to POINT.
    - A BtnL edge and a Step in the same cycle counts as a hit: Bounce fires and that Step's pattern is still decoded.
    - BtnR is ignored in this state.
  - AT_RIGHT: mirror of AT_LEFT using BtnR, with a miss incrementing ScoreL.
  - POINT:
    - If the incremented score equals WIN_SCORE, set Winner and go to GAMEOVER.
    - Otherwise go to IDLE on the next cycle.
  - GAMEOVER: outputs are frozen, all inputs are ignored, and Err is not generated. Only Rst leaves this state.
- Score arithmetic: scores are unsigned and saturate at WIN_SCORE; they never wrap.
- Bounce is never asserted on two consecutive cycles.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding constants (IDLE, RALLY, AT_LEFT, AT_RIGHT, POINT, GAMEOVER);
  - default WIDTH, SCORE_W and WIN_SCORE;
  - Winner encodings.
- One sub-module, pong_btn_edge: registers one button and outputs a 1-cycle rising-edge pulse, with the same synchronous active-low Rst. It is instantiated twice.
- The one-hot decode and validity check stay inline.

Test Plan:
- Steps with Pattern 0x01, 0x02, 0x04 -> Pos 0, 1, 2; Dir=1; Err=0; state RALLY after the first Step.
- Steps up to Pattern 0x80, then BtnL rises before the next Step -> one Bounce pulse, Dir=0, ScoreR unchanged.
- Steps up to Pattern 0x80 with no BtnL, then Step with 0x40 -> ScoreR 0 to 1, state POINT then IDLE.
- Pattern 0x80 reached, then BtnL edge and Step in the same cycle -> Bounce=1, no score change.
- Step with Pattern 0x00, then 0x18, then a jump from 0x02 to 0x10 -> three Err pulses, Pos unchanged from the last legal value.
- Eight right-end misses, then a ninth -> ScoreL=9, Winner=10, GAMEOVER with frozen outputs; asserting Rst mid-game clears everything on the next edge.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants and state encoding for the pong rally judge
package pong_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SCORE_W   = 4;
    localparam int DEF_WIN_SCORE = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RALLY    = 3'd1,
        ST_AT_LEFT  = 3'd2,
        ST_AT_RIGHT = 3'd3,
        ST_POINT    = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_e;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/pong_btn_edge.sv
// rtl/pong_btn_edge.sv - registers one debounced button and emits a 1-cycle rising-edge pulse
module pong_btn_edge (
    input  logic Clk,
    input  logic Rst,
    input  logic btn_i,
    output logic rise_o
);

    logic cur_q;
    logic prev_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= btn_i;
            prev_q <= cur_q;
        end
    end

    assign rise_o = cur_q & ~prev_q;

endmodule

// File: rtl/pong_rally_judge.sv
// rtl/pong_rally_judge.sv - decodes the LED ball pattern, judges paddle hits, keeps score
module pong_rally_judge
    import pong_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int WIN_SCORE = DEF_WIN_SCORE
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [WIDTH-1:0]         Pattern,
    input  logic                     Step,
    input  logic                     BtnL,
    input  logic                     BtnR,
    output logic                     Bounce,
    output logic [$clog2(WIDTH)-1:0] Pos,
    output logic                     Dir,
    output logic [SCORE_W-1:0]       ScoreL,
    output logic [SCORE_W-1:0]       ScoreR,
    output logic [1:0]               Winner,
    output logic                     Err
);

    localparam int                 POS_W    = $clog2(WIDTH);
    localparam logic [POS_W-1:0]   LAST_IDX = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0]   HALF_IDX = POS_W'(WIDTH / 2);
    localparam logic [POS_W:0]     ONE_P    = (POS_W + 1)'(1);
    localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ONE_S    = SCORE_W'(1);

    state_e               state_q;
    logic [POS_W-1:0]     pos_q;
    logic                 dir_q;
    logic [SCORE_W-1:0]   score_l_q;
    logic [SCORE_W-1:0]   score_r_q;
    logic [1:0]           winner_q;
    logic                 bounce_q;
    logic                 err_q;

    logic                 edge_l;
    logic                 edge_r;
    logic                 pat_any;
    logic                 pat_multi;
    logic                 pat_legal;
    logic [POS_W-1:0]     pat_idx;
    logic                 step_up;
    logic                 step_down;

    pong_btn_edge u_btn_l (
        .Clk    (Clk),
        .Rst    (Rst),
        .btn_i  (BtnL),
        .rise_o (edge_l)
    );

    pong_btn_edge u_btn_r (
        .Clk    (Clk),
        .Rst    (Rst),
        .btn_i  (BtnR),
        .rise_o (edge_r)
    );

    // One-hot decode: a second set bit marks the pattern illegal.
    always_comb begin
        pat_any   = 1'b0;
        pat_multi = 1'b0;
        pat_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (Pattern[i]) begin
                if (pat_any) begin
                    pat_multi = 1'b1;
                end
                pat_any = 1'b1;
                pat_idx = POS_W'(i);
            end
        end
    end

    assign pat_legal = pat_any & ~pat_multi;
    // Extra top bit keeps the +-1 comparison from wrapping at the ends.
    assign step_up   = ({1'b0, pat_idx} == ({1'b0, pos_q} + ONE_P));
    assign step_down = ({1'b0, pos_q} == ({1'b0, pat_idx} + ONE_P));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= WIN_NONE;
            bounce_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bounce_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Step) begin
                        if (pat_legal) begin
                            pos_q   <= pat_idx;
                            dir_q   <= (pat_idx < HALF_IDX);
                            state_q <= ST_RALLY;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RALLY: begin
                    if (Step) begin
                        if (!pat_legal) begin
                            err_q <= 1'b1;
                        end else if (step_up) begin
                            pos_q <= pat_idx;
                            dir_q <= 1'b1;
                            if (pat_idx == LAST_IDX) begin
                                state_q <= ST_AT_LEFT;
                            end
                        end else if (step_down) begin
                            pos_q <= pat_idx;
                            dir_q <= 1'b0;
                            if (pat_idx == '0) begin
                                state_q <= ST_AT_RIGHT;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_AT_LEFT: begin
                    if (edge_l) begin
                        bounce_q <= 1'b1;
                        dir_q    <= 1'b0;
                        state_q  <= ST_RALLY;
                        // A hit on the same cycle as a Step still decodes that Step.
                        if (Step) begin
                            if (pat_legal && (step_up || step_down)) begin
                                pos_q <= pat_idx;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end else if (Step) begin
                        if (score_r_q != WIN_S) begin
                            score_r_q <= score_r_q + ONE_S;
                        end
                        state_q <= ST_POINT;
                    end
                end
                ST_AT_RIGHT: begin
                    if (edge_r) begin
                        bounce_q <= 1'b1;
                        dir_q    <= 1'b1;
                        state_q  <= ST_RALLY;
                        if (Step) begin
                            if (pat_legal && (step_up || step_down)) begin
                                pos_q <= pat_idx;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end else if (Step) begin
                        if (score_l_q != WIN_S) begin
                            score_l_q <= score_l_q + ONE_S;
                        end
                        state_q <= ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (score_l_q == WIN_S) begin
                        winner_q <= WIN_LEFT;
                        state_q  <= ST_GAMEOVER;
                    end else if (score_r_q == WIN_S) begin
                        winner_q <= WIN_RIGHT;
                        state_q  <= ST_GAMEOVER;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAMEOVER: begin
                    state_q <= ST_GAMEOVER;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Bounce = bounce_q;
    assign Pos    = pos_q;
    assign Dir    = dir_q;
    assign ScoreL = score_l_q;
    assign ScoreR = score_r_q;
    assign Winner = winner_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_pong_rally_judge.sv
// tb/tb_pong_rally_judge.sv - directed and randomized checks of pong_rally_judge against a rule model
module tb_pong_rally_judge;

    localparam int M_IDLE  = 0;
    localparam int M_RALLY = 1;
    localparam int M_LEFT  = 2;
    localparam int M_RIGHT = 3;
    localparam int M_POINT = 4;
    localparam int M_OVER  = 5;

    logic       Clk;
    logic       Rst;
    logic [7:0] Pattern;
    logic       Step;
    logic       BtnL;
    logic       BtnR;
    logic       Bounce;
    logic [2:0] Pos;
    logic       Dir;
    logic [3:0] ScoreL;
    logic [3:0] ScoreR;
    logic [1:0] Winner;
    logic       Err;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode, m_pos, m_dir, m_sl, m_sr, m_win, m_bounce, m_err;
    int hl1, hl2, hr1, hr2;
    int bounce_seen, err_seen;
    logic bl_lvl, br_lvl;
    int gen_pos, gen_dir, over_cnt;

    pong_rally_judge #(
        .WIDTH     (8),
        .SCORE_W   (4),
        .WIN_SCORE (9)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Pattern (Pattern),
        .Step    (Step),
        .BtnL    (BtnL),
        .BtnR    (BtnR),
        .Bounce  (Bounce),
        .Pos     (Pos),
        .Dir     (Dir),
        .ScoreL  (ScoreL),
        .ScoreR  (ScoreR),
        .Winner  (Winner),
        .Err     (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Rule model: one call per rising edge with the inputs present at that edge.
    task automatic model_edge(input logic rst, input logic st, input logic [7:0] pat,
                              input logic bl, input logic br);
        int ones, n, d, rise_l, rise_r;
        if (!rst) begin
            m_mode = M_IDLE; m_pos = 0; m_dir = 0; m_sl = 0; m_sr = 0;
            m_win = 0; m_bounce = 0; m_err = 0;
            hl1 = 0; hl2 = 0; hr1 = 0; hr2 = 0;
            return;
        end
        rise_l = (hl1 == 1 && hl2 == 0) ? 1 : 0;
        rise_r = (hr1 == 1 && hr2 == 0) ? 1 : 0;
        hl2 = hl1; hl1 = int'(bl);
        hr2 = hr1; hr1 = int'(br);
        m_bounce = 0;
        m_err = 0;
        ones = $countones(pat);
        n = 0;
        for (int i = 0; i < 8; i++) if (pat[i]) n = i;
        d = n - m_pos;
        case (m_mode)
            M_IDLE: if (st) begin
                if (ones == 1) begin
                    m_pos = n; m_dir = (n >= 4) ? 0 : 1; m_mode = M_RALLY;
                end else m_err = 1;
            end
            M_RALLY: if (st) begin
                if (ones != 1) m_err = 1;
                else if (d == 1) begin
                    m_pos = n; m_dir = 1; if (n == 7) m_mode = M_LEFT;
                end else if (d == -1) begin
                    m_pos = n; m_dir = 0; if (n == 0) m_mode = M_RIGHT;
                end else m_err = 1;
            end
            M_LEFT, M_RIGHT: begin
                if ((m_mode == M_LEFT && rise_l == 1) || (m_mode == M_RIGHT && rise_r == 1)) begin
                    m_bounce = 1;
                    m_dir = (m_mode == M_LEFT) ? 0 : 1;
                    m_mode = M_RALLY;
                    if (st) begin
                        if (ones == 1 && (d == 1 || d == -1)) m_pos = n;
                        else m_err = 1;
                    end
                end else if (st) begin
                    if (m_mode == M_LEFT) m_sr = (m_sr < 9) ? m_sr + 1 : 9;
                    else m_sl = (m_sl < 9) ? m_sl + 1 : 9;
                    m_mode = M_POINT;
                end
            end
            M_POINT: begin
                if (m_sl == 9) begin m_win = 2; m_mode = M_OVER; end
                else if (m_sr == 9) begin m_win = 1; m_mode = M_OVER; end
                else m_mode = M_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input logic rst, input logic st, input logic [7:0] pat,
                       input logic bl, input logic br);
        Rst = rst; Step = st; Pattern = pat; BtnL = bl; BtnR = br;
        @(posedge Clk);
        model_edge(rst, st, pat, bl, br);
        @(negedge Clk);
        bounce_seen += int'(Bounce);
        err_seen    += int'(Err);
        check_eq("pos",    32'(Pos),    m_pos);
        check_eq("dir",    32'(Dir),    m_dir);
        check_eq("scoreL", 32'(ScoreL), m_sl);
        check_eq("scoreR", 32'(ScoreR), m_sr);
        check_eq("winner", 32'(Winner), m_win);
        check_eq("bounce", 32'(Bounce), m_bounce);
        check_eq("err",    32'(Err),    m_err);
    endtask

    task automatic stp(input logic [7:0] pat);
        cyc(1'b1, 1'b1, pat, bl_lvl, br_lvl);
        cyc(1'b1, 1'b0, 8'h00, bl_lvl, br_lvl);
    endtask

    initial begin
        logic [7:0] pat;
        logic rst, st;
        bl_lvl = 1'b0; br_lvl = 1'b0;
        bounce_seen = 0; err_seen = 0;
        m_mode = M_IDLE; hl1 = 0; hl2 = 0; hr1 = 0; hr2 = 0;

        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
        check_eq("rst_pos", 32'(Pos), 0);
        check_eq("rst_winner", 32'(Winner), 0);
        err_seen = 0; bounce_seen = 0;

        stp(8'h01); stp(8'h02); stp(8'h04);
        check_eq("tp1_pos", 32'(Pos), 2);
        check_eq("tp1_dir", 32'(Dir), 1);
        check_eq("tp1_errs", 32'(err_seen), 0);

        stp(8'h08); stp(8'h10); stp(8'h20); stp(8'h40); stp(8'h80);
        bl_lvl = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 8'h00, bl_lvl, br_lvl);
        bl_lvl = 1'b0;
        check_eq("tp2_bounces", 32'(bounce_seen), 1);
        check_eq("tp2_dir", 32'(Dir), 0);
        check_eq("tp2_scoreR", 32'(ScoreR), 0);

        stp(8'h40); stp(8'h20); stp(8'h10); stp(8'h08); stp(8'h04); stp(8'h02); stp(8'h01);
        stp(8'h02);
        check_eq("miss_right_scoreL", 32'(ScoreL), 1);

        stp(8'h08); stp(8'h10); stp(8'h20); stp(8'h40); stp(8'h80);
        stp(8'h40);
        check_eq("tp3_scoreR", 32'(ScoreR), 1);
        check_eq("tp3_scoreL", 32'(ScoreL), 1);

        stp(8'h08); stp(8'h10); stp(8'h20); stp(8'h40); stp(8'h80);
        bounce_seen = 0;
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
        check_eq("tp4_bounce", 32'(Bounce), 1);
        check_eq("tp4_pos", 32'(Pos), 6);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("tp4_scoreR", 32'(ScoreR), 1);

        err_seen = 0;
        stp(8'h00); stp(8'h18);
        check_eq("tp5_pos_hold", 32'(Pos), 6);
        stp(8'h20); stp(8'h10); stp(8'h08); stp(8'h04); stp(8'h02);
        stp(8'h10);
        check_eq("tp5_errs", 32'(err_seen), 3);
        check_eq("tp5_pos", 32'(Pos), 1);

        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            stp(8'h10); stp(8'h08); stp(8'h04); stp(8'h02); stp(8'h01);
            stp(8'h02);
            if (k == 8) begin
                check_eq("tp6_scoreL8", 32'(ScoreL), 8);
                check_eq("tp6_winner8", 32'(Winner), 0);
            end
        end
        check_eq("tp6_scoreL9", 32'(ScoreL), 9);
        check_eq("tp6_winner", 32'(Winner), 2);
        err_seen = 0; bounce_seen = 0;
        for (int k = 0; k < 20; k++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_eq("over_winner", 32'(Winner), 2);
        check_eq("over_scoreL", 32'(ScoreL), 9);
        check_eq("over_errs", 32'(err_seen), 0);
        cyc(1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
        check_eq("over_rst_scoreL", 32'(ScoreL), 0);
        check_eq("over_rst_winner", 32'(Winner), 0);
        check_eq("over_rst_pos", 32'(Pos), 0);

        gen_pos = 0; gen_dir = 1; over_cnt = 0;
        bl_lvl = 1'b0; br_lvl = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            rst = ($urandom_range(0, 1499) != 0);
            if (m_mode == M_OVER) begin
                over_cnt++;
                if (over_cnt > 25) begin rst = 1'b0; over_cnt = 0; end
            end
            st = ($urandom_range(0, 2) == 0);
            pat = 8'h00;
            if (st) begin
                if ($urandom_range(0, 11) == 0) pat = 8'($urandom_range(0, 255));
                else begin
                    if (gen_pos + gen_dir > 7 || gen_pos + gen_dir < 0) gen_dir = -gen_dir;
                    gen_pos = gen_pos + gen_dir;
                    pat = 8'(1 << gen_pos);
                end
            end
            if ($urandom_range(0, 4) == 0) bl_lvl = ~bl_lvl;
            if ($urandom_range(0, 4) == 0) br_lvl = ~br_lvl;
            cyc(rst, st, pat, bl_lvl, br_lvl);
            if (m_bounce == 1) gen_dir = (gen_pos >= 4) ? -1 : 1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
